mips_bootmem: RTL and testbench
===============================

Name: mips_bootmem

Overview:
- Byte-wide synchronous memory that sits directly upstream of the 8-bit multicycle mips core.
- Supplies `memdata` from the core's `adr`/`memread` requests and accepts `writedata` on `memwrite`.
- Contains a boot loader. It streams a program image into memory from address 0 and holds the core in reset until loading completes.
- Instructions are fetched as four consecutive bytes, assembled by the core via `irwrite`.

Parameters:
- ADDR_W, 8, address width; memory depth DEPTH = 2**ADDR_W bytes.
- DATA_W, 8, data width; must equal the core's `memdata` width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  core read request, sampled on clk.
- memwrite  input  1  core write request, sampled on clk.
- adr  input  ADDR_W  core byte address.
- writedata  input  DATA_W  core write data.
- memdata  output  DATA_W  registered read data to the core.
- load_valid  input  1  loader byte valid.
- load_data  input  DATA_W  loader byte.
- load_last  input  1  marks the final byte of the image; qualified by load_valid.
- load_ready  output  1  block accepts loader bytes.
- reload  input  1  single-cycle request to re-enter LOAD from RUN.
- cpu_reset  output  1  active-high reset driven to the mips core.
- load_count  output  ADDR_W+1  number of bytes accepted in the current load.

Behaviour:
- Storage: DEPTH x DATA_W register array. Contents are not cleared by reset or reload. Reading a location never loaded returns unspecified data.
- State machine, two states, LOAD and RUN:
  - reset: state=LOAD, load_ptr=0, load_count=0, memdata=0, cpu_reset=1, load_ready=1. The reset=1 cycle accepts no loader byte and performs no core access.
  - LOAD:
    - load_ready=1, cpu_reset=1. Core memread/memwrite are ignored; memdata holds 0.
    - On load_valid&load_ready: mem[load_ptr] <= load_data; load_ptr++; load_count++.
    - load_valid low: no change; gaps of any length are allowed.
  - LOAD->RUN: on the cycle a byte is accepted with load_last=1, or the byte is accepted at load_ptr==DEPTH-1 (image full, load_last not required).
    - Next cycle: state=RUN, load_ready=0, cpu_reset=0.
    - cpu_reset falls exactly one clock after the final byte's accepting edge.
    - load_count holds the final count (DEPTH max, hence ADDR_W+1 bits). load_ptr never wraps.
  - RUN:
    - load_ready=0; load_valid is ignored.
    - memwrite=1: mem[adr] <= writedata at the edge.
    - memread=1: memdata <= mem[adr] at the edge. Latency is 1 clock, matching the core's byte-per-cycle instruction fetch.
    - memread&memwrite both set: write is performed; memdata returns the OLD contents (read-before-write).
    - Neither asserted: memdata holds its previous value.
  - RUN->LOAD: reload=1 for one cycle. Next cycle: state=LOAD, cpu_reset=1, load_ready=1, load_ptr=0, load_count=0, memdata=0. A core write in the same cycle as reload is still performed.
  - reload in LOAD: no effect.
- Precedence: reset overrides all; reload overrides core access for state but not for the coincident write.
- Mid-operation reset (LOAD or RUN): returns to the reset values above. A partially loaded image is discarded from the count but bytes remain in the array.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Boot 4 bytes: reset 1 cycle, then stream 20,08,43,00 on consecutive cycles with load_last on 00 -> load_count=4; cpu_reset=1 through the 00 accept edge, 0 on the following cycle; load_ready=0.
- Fetch: after boot, memread=1 with adr=0,1,2,3 on consecutive cycles -> memdata=20,08,43,00, each valid one clock after its request; memread=0 thereafter -> memdata holds 00.
- Write/read and collision: memwrite adr=10 data=5A, then memread adr=10 -> memdata=5A. Then memread&memwrite adr=10 data=A5 -> memdata=5A; next read -> A5.
- Loader gaps and full image: load_valid toggles 1,0,0,1... -> only valid cycles counted. Stream 256 bytes without load_last -> RUN entered after byte 255 is accepted; load_count=256; byte 257 is not accepted (load_ready=0).
- Isolation in LOAD: memwrite adr=3 data=FF and memread during LOAD -> mem[3] unchanged, memdata stays 0.
- Reload and mid-load reset: reload in RUN -> cpu_reset=1, load_count=0 next cycle, new image overwrites from 0. Reset asserted after 2 of 4 bytes -> load_count=0, state LOAD; full restream boots correctly.

Source files
------------

// File: rtl/mips_bootmem.sv
// rtl/mips_bootmem.sv - byte-wide boot memory for the 8-bit multicycle mips core
// Streams a program image in from address 0, then serves core reads/writes.
module mips_bootmem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] load_ptr;
  logic              accept;
  logic              image_done;
  logic              core_rd;
  logic              core_wr;
  logic              reload_run;

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    image_done = 1'b0;
    core_rd    = 1'b0;
    core_wr    = 1'b0;
    reload_run = 1'b0;
    case (state)
      LOAD: begin
        accept     = load_valid & load_ready;
        // a full array ends the image even without load_last
        image_done = accept & (load_last | (load_ptr == LAST_ADR));
        if (image_done) state_n = RUN;
      end
      RUN: begin
        core_rd    = memread;
        core_wr    = memwrite;
        reload_run = reload;
        if (reload) state_n = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      load_count <= '0;
      memdata    <= '0;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b1;
    end else begin
      state      <= state_n;
      cpu_reset  <= (state_n == LOAD);
      load_ready <= (state_n == LOAD);
      if (accept) begin
        if (load_ptr != LAST_ADR) load_ptr <= load_ptr + ADDR_W'(1);
        load_count <= load_count + (ADDR_W+1)'(1);
      end
      if (reload_run) begin
        load_ptr   <= '0;
        load_count <= '0;
        memdata    <= '0;
      end else if (core_rd) begin
        memdata <= mem[adr];
      end
    end
  end

  // Array contents survive reset and reload; the reset cycle touches nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept)       mem[load_ptr] <= load_data;
      else if (core_wr) mem[adr]      <= writedata;
    end
  end

endmodule

// File: tb/tb_mips_bootmem.sv
// tb/tb_mips_bootmem.sv - scoreboard bench for mips_bootmem
// Driver pushes per-cycle expectations from a reference model; monitor pops and compares.
module tb_mips_bootmem;

  logic       clk = 1'b0;
  logic       reset = 1'b0, memread = 1'b0, memwrite = 1'b0;
  logic [7:0] adr = '0, writedata = '0, memdata;
  logic       load_valid = 1'b0, load_last = 1'b0, load_ready, reload = 1'b0, cpu_reset;
  logic [7:0] load_data = '0;
  logic [8:0] load_count;

  always #5 clk = ~clk;

  mips_bootmem #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .reload(reload), .cpu_reset(cpu_reset),
    .load_count(load_count)
  );

  typedef struct {
    bit         md_chk;
    logic [7:0] md;
    bit         cr;
    bit         lr;
    logic [8:0] lc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  bit         m_run = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_md = '0;
  bit         m_mdk = 1'b0;
  logic [7:0] mm [256];
  bit         mk [256];

  task automatic step(input bit rs, input bit rd, input bit wr, input logic [7:0] a,
                      input logic [7:0] wd, input bit lv, input logic [7:0] ld,
                      input bit ll, input bit rl);
    exp_t       e;
    logic [7:0] old;
    bit         oldk;
    @(negedge clk);
    reset = rs; memread = rd; memwrite = wr; adr = a; writedata = wd;
    load_valid = lv; load_data = ld; load_last = ll; reload = rl;
    if (rs) begin
      m_run = 1'b0; m_cnt = 0; m_md = '0; m_mdk = 1'b1;
    end else if (!m_run) begin
      if (lv) begin
        mm[m_cnt] = ld; mk[m_cnt] = 1'b1; m_cnt++;
        if (ll || m_cnt == 256) m_run = 1'b1;
      end
    end else begin
      old = mm[a]; oldk = mk[a];
      if (wr) begin mm[a] = wd; mk[a] = 1'b1; end
      if (rd) begin m_md = old; m_mdk = oldk; end
      if (rl) begin m_run = 1'b0; m_cnt = 0; m_md = '0; m_mdk = 1'b1; end
    end
    e.md_chk = m_mdk; e.md = m_md; e.cr = !m_run; e.lr = !m_run; e.lc = 9'(m_cnt);
    q.push_back(e);
  endtask

  task automatic idle();                             step(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0); endtask
  task automatic do_reset();                         step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0); endtask
  task automatic ld(input logic [7:0] d, input bit l); step(0, 0, 0, 8'h00, 8'h00, 1, d, l, 0); endtask
  task automatic rd(input logic [7:0] a);            step(0, 1, 0, a, 8'h00, 0, 8'h00, 0, 0); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d); step(0, 0, 1, a, d, 0, 8'h00, 0, 0); endtask

  task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cpu_reset", {8'b0, cpu_reset}, {8'b0, e.cr});
      chk("load_ready", {8'b0, load_ready}, {8'b0, e.lr});
      chk("load_count", load_count, e.lc);
      if (e.md_chk) chk("memdata", {1'b0, memdata}, {1'b0, e.md});
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mm[i] = '0; mk[i] = 1'b0; end

    do_reset();
    ld(8'h20, 0); ld(8'h08, 0); ld(8'h43, 0); ld(8'h00, 1);
    rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3); idle(); idle();
    wr(8'd10, 8'h5A); rd(8'd10);
    step(0, 1, 1, 8'd10, 8'hA5, 0, 8'h00, 0, 0); rd(8'd10); idle();

    // reload with a coincident write, then core traffic during LOAD must be ignored
    step(0, 0, 1, 8'd20, 8'h77, 0, 8'h00, 0, 1);
    step(0, 1, 1, 8'd3, 8'hFF, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'd3, 8'h00, 0, 8'h00, 0, 1);
    ld(8'h11, 0); ld(8'h22, 1);
    rd(8'd3); rd(8'd0); rd(8'd1); rd(8'd20);

    // mid-load reset, then full restream
    step(0, 0, 0, 8'd0, 8'h00, 0, 8'h00, 0, 1);
    ld(8'hAA, 0); ld(8'hBB, 0); do_reset(); idle();
    ld(8'h20, 0); ld(8'h08, 0); ld(8'h43, 0); ld(8'h00, 1);
    rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3);

    // gapped loader: valid 1,0,0 repeating
    step(0, 0, 0, 8'd0, 8'h00, 0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) begin
      ld(8'($urandom), i == 5);
      step(0, 0, 0, 8'd0, 8'h00, 0, 8'($urandom), 1, 0);
      idle();
    end
    for (int i = 0; i < 7; i++) rd(8'(i));

    // full 256-byte image without load_last, plus a 257th offered byte
    step(0, 0, 0, 8'd0, 8'h00, 0, 8'h00, 0, 1);
    for (int i = 0; i < 256; i++) ld(8'($urandom), 0);
    ld(8'hEE, 1); ld(8'hEF, 0);
    rd(8'd0); rd(8'd255); rd(8'd128);
    for (int i = 0; i < 10; i++) rd(8'($urandom));

    // randomized mix of everything
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
           8'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);

    @(negedge clk); reset = 0; memread = 0; memwrite = 0; load_valid = 0; reload = 0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", 9'(q.size()), 9'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
